// File: rtl/prime_sieve_engine.sv
// prime_sieve_engine
// Sieve of Eratosthenes over 0..N-1 held in a 1-bit composite array, followed
// by a bidirectional prime step iterator once the sieve has finished.
// Optional feature: define PRIME_SIEVE_COUNT_EN to add a COUNT pass and the
// prime_count output (number of primes in 2..N-1).
`timescale 1ns/1ps

module prime_sieve_engine #(
    parameter int N  = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          req,
    input  logic          dir,
    output logic          ready,
    output logic [AW-1:0] prime_o,
    output logic          prime_valid,
    output logic          wrapped
`ifdef PRIME_SIEVE_COUNT_EN
    ,
    output logic [AW:0]   prime_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FIND,
        S_MARK,
`ifdef PRIME_SIEVE_COUNT_EN
        S_COUNT,
`endif
        S_DONE
    } state_t;

    // Width-matched constants so every compare and add is exact.
    localparam logic [AW-1:0]   IDX_ZERO = '0;
    localparam logic [AW-1:0]   IDX_ONE  = AW'(1);
    localparam logic [AW-1:0]   IDX_TWO  = AW'(2);
    localparam logic [AW-1:0]   IDX_LAST = AW'(N - 1);
    localparam logic [AW:0]     N_M      = (AW + 1)'(N);
    localparam logic [2*AW-1:0] N_PP     = (2 * AW)'(N);
`ifdef PRIME_SIEVE_COUNT_EN
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
`endif

    state_t          state;
    logic [N-1:0]    comp;          // bit k = 1 means k is composite
    logic [AW-1:0]   idx;           // CLEAR / COUNT walk index
    logic [AW-1:0]   p;             // current sieve base
    logic [AW:0]     m;             // current multiple being marked
    logic [AW-1:0]   cursor;        // last prime reported by the iterator
    logic [AW-1:0]   pos;           // index under test during a scan
    logic            scanning;
    logic            scan_dir;
    logic            scan_wrap;     // sticky: the current scan crossed an end

    logic [2*AW-1:0] pp;
    logic [AW:0]     m_next;
    logic [AW:0]     req_step;      // {wrap, index} one step from cursor
    logic [AW:0]     scan_step;     // {wrap, index} one step from pos
    logic            start_ok;
    logic            req_ok;

    // One iterator step with wrap-around; indices 0 and 1 are never visited.
    function automatic logic [AW:0] step_idx(input logic [AW-1:0] i, input logic d);
        logic [AW:0] r;
        if (!d) begin
            if (i >= IDX_LAST) r = {1'b1, IDX_TWO};
            else               r = {1'b0, i + IDX_ONE};
        end else begin
            if (i <= IDX_TWO)  r = {1'b1, IDX_LAST};
            else               r = {1'b0, i - IDX_ONE};
        end
        return r;
    endfunction

    // p*p at double width and m+p at one extra bit so neither can wrap.
    assign pp        = {{AW{1'b0}}, p} * {{AW{1'b0}}, p};
    assign m_next    = m + {1'b0, p};
    assign req_step  = step_idx(cursor, dir);
    assign scan_step = step_idx(pos, scan_dir);

    // start is honoured only when no run is in progress; it beats a same-cycle req.
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign req_ok   = (state == S_DONE) && ready && req && !start;

    // Composite array: deliberately unreset, rewritten by every CLEAR pass.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            comp[idx] <= 1'b0;
        else if (state == S_MARK)
            comp[m[AW-1:0]] <= 1'b1;
    end

    // Main controller: sieve FSM, DONE-entry setup and the step iterator.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b0;
            prime_o     <= '0;
            prime_valid <= 1'b0;
            wrapped     <= 1'b0;
            cursor      <= IDX_TWO;
            p           <= IDX_TWO;
            m           <= '0;
            idx         <= IDX_ZERO;
            pos         <= IDX_TWO;
            scanning    <= 1'b0;
            scan_dir    <= 1'b0;
            scan_wrap   <= 1'b0;
`ifdef PRIME_SIEVE_COUNT_EN
            prime_count <= '0;
`endif
        end else begin
            prime_valid <= 1'b0;
            wrapped     <= 1'b0;
            if (start_ok) begin
                // New run: drop results, abort any scan, start clearing.
                state    <= S_CLEAR;
                idx      <= IDX_ZERO;
                busy     <= 1'b1;
                done     <= 1'b0;
                ready    <= 1'b0;
                scanning <= 1'b0;
`ifdef PRIME_SIEVE_COUNT_EN
                prime_count <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_CLEAR: begin
                        if (idx == IDX_LAST) begin
                            p     <= IDX_TWO;
                            state <= S_FIND;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                    S_FIND: begin
                        if (pp >= N_PP) begin
`ifdef PRIME_SIEVE_COUNT_EN
                            idx   <= IDX_TWO;
                            state <= S_COUNT;
`else
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            cursor      <= IDX_TWO;
                            prime_o     <= IDX_TWO;
                            ready       <= 1'b1;
                            prime_valid <= 1'b1;
`endif
                        end else if (comp[p]) begin
                            p <= p + IDX_ONE;
                        end else begin
                            // pp < N here, so the low AW bits hold it exactly.
                            m     <= {1'b0, pp[AW-1:0]};
                            state <= S_MARK;
                        end
                    end
                    S_MARK: begin
                        if (m_next >= N_M) begin
                            p     <= p + IDX_ONE;
                            state <= S_FIND;
                        end else begin
                            m <= m_next;
                        end
                    end
`ifdef PRIME_SIEVE_COUNT_EN
                    S_COUNT: begin
                        if (!comp[idx])
                            prime_count <= prime_count + CNT_ONE;
                        if (idx == IDX_LAST) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            cursor      <= IDX_TWO;
                            prime_o     <= IDX_TWO;
                            ready       <= 1'b1;
                            prime_valid <= 1'b1;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
`endif
                    S_DONE: begin
                        if (req_ok) begin
                            ready     <= 1'b0;
                            scanning  <= 1'b1;
                            scan_dir  <= dir;
                            scan_wrap <= req_step[AW];
                            pos       <= req_step[AW-1:0];
                        end else if (scanning) begin
                            if (!comp[pos]) begin
                                cursor      <= pos;
                                prime_o     <= pos;
                                prime_valid <= 1'b1;
                                wrapped     <= scan_wrap;
                                ready       <= 1'b1;
                                scanning    <= 1'b0;
                            end else begin
                                pos       <= scan_step[AW-1:0];
                                scan_wrap <= scan_wrap | scan_step[AW];
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
